// File: rtl/axi_tagctrl_tag_arb.sv
// Tag-cache request arbiter: round-robins read lookups and write updates onto one port and routes responses back in order.
// Optional macro AXI_TAGCTRL_ARB_PERF_EN adds saturating grant/stall counters.
module axi_tagctrl_tag_arb #(
  parameter int unsigned          AddrWidth       = 64,
  parameter int unsigned          DataWidth       = 64,
  parameter int unsigned          CapSize         = 128,
  parameter logic [AddrWidth-1:0] DRAMMemBase     = 'h8000_0000,
  parameter logic [AddrWidth-1:0] DRAMMemLength   = 'h4000_0000,
  parameter logic [AddrWidth-1:0] TagCacheMemBase = 'h8FF0_0000,
  parameter int unsigned          MaxOutstanding  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rd_req_valid_i,
  output logic                         rd_req_ready_o,
  input  logic [AddrWidth-1:0]         rd_req_addr_i,
  output logic                         rd_rsp_valid_o,
  input  logic                         rd_rsp_ready_i,
  output logic                         rd_rsp_tag_o,
  output logic                         rd_rsp_err_o,
  input  logic                         wr_req_valid_i,
  output logic                         wr_req_ready_o,
  input  logic [AddrWidth-1:0]         wr_req_addr_i,
  input  logic                         wr_req_tag_i,
  output logic                         wr_rsp_valid_o,
  input  logic                         wr_rsp_ready_i,
  output logic                         wr_rsp_err_o,
  output logic                         tc_req_valid_o,
  input  logic                         tc_req_ready_i,
  output logic [AddrWidth-1:0]         tc_req_addr_o,
  output logic                         tc_req_we_o,
  output logic [$clog2(DataWidth)-1:0] tc_req_bit_o,
  output logic                         tc_req_wbit_o,
  input  logic                         tc_rsp_valid_i,
  output logic                         tc_rsp_ready_o,
  input  logic                         tc_rsp_tag_i
`ifdef AXI_TAGCTRL_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_rd_grants_o,
  output logic [31:0]                  perf_wr_grants_o,
  output logic [31:0]                  perf_stall_o
`endif
);

  localparam int unsigned CapShift  = $clog2(CapSize / 8);
  localparam int unsigned BitW      = $clog2(DataWidth);
  localparam int unsigned ByteShift = $clog2(DataWidth / 8);
  localparam int unsigned PtrW      = $clog2(MaxOutstanding);

  logic [PtrW:0]   countReg;
  logic [PtrW-1:0] wrPtrReg, rdPtrReg;
  logic            rrWrReg, lockedReg, lockSrcReg;
  logic [1:0]      fifoMem [MaxOutstanding];

  logic                 grantWr, selValid, selInRange, canPush, accept, pop, fifoFull, fifoEmpty;
  logic                 headSrcWr, headLocal, rspForRd, rspForWr;
  logic [1:0]           headEntry;
  logic [AddrWidth-1:0] selAddr, offset;
  logic [AddrWidth:0]   upperBound;

  // While locked the previous grant is held; otherwise round-robin only matters when both compete.
  always_comb begin
    grantWr = wr_req_valid_i;
    if (lockedReg) begin
      grantWr = lockSrcReg;
    end else if (rd_req_valid_i && wr_req_valid_i) begin
      grantWr = rrWrReg;
    end
  end

  assign selValid   = grantWr ? wr_req_valid_i : rd_req_valid_i;
  assign selAddr    = grantWr ? wr_req_addr_i : rd_req_addr_i;
  assign offset     = (selAddr - DRAMMemBase) >> CapShift;
  assign upperBound = {1'b0, DRAMMemBase} + {1'b0, DRAMMemLength};
  assign selInRange = ({1'b0, selAddr} >= {1'b0, DRAMMemBase}) && ({1'b0, selAddr} < upperBound);

  assign tc_req_addr_o  = TagCacheMemBase + ((offset >> BitW) << ByteShift);
  assign tc_req_bit_o   = offset[BitW-1:0];
  assign tc_req_we_o    = grantWr;
  assign tc_req_wbit_o  = grantWr & wr_req_tag_i;

  assign fifoEmpty = (countReg == '0);
  assign fifoFull  = (countReg == (PtrW + 1)'(MaxOutstanding));
  assign headEntry = fifoMem[rdPtrReg];
  assign headSrcWr = headEntry[1];
  assign headLocal = headEntry[0];
  assign rspForRd  = !fifoEmpty && !headSrcWr;
  assign rspForWr  = !fifoEmpty && headSrcWr;

  assign rd_rsp_valid_o = rspForRd && (headLocal || tc_rsp_valid_i);
  assign rd_rsp_err_o   = rspForRd && headLocal;
  assign rd_rsp_tag_o   = rspForRd && !headLocal && tc_rsp_tag_i;
  assign wr_rsp_valid_o = rspForWr && (headLocal || tc_rsp_valid_i);
  assign wr_rsp_err_o   = rspForWr && headLocal;
  assign tc_rsp_ready_o = !fifoEmpty && !headLocal && (headSrcWr ? wr_rsp_ready_i : rd_rsp_ready_i);

  assign pop = (rd_rsp_valid_o && rd_rsp_ready_i) || (wr_rsp_valid_o && wr_rsp_ready_i);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept alongside it.
  assign canPush = !fifoFull || pop;

  assign tc_req_valid_o = selValid && selInRange && canPush;
  assign accept         = selValid && canPush && (!selInRange || tc_req_ready_i);
  assign rd_req_ready_o = accept && !grantWr;
  assign wr_req_ready_o = accept && grantWr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      countReg   <= '0;
      wrPtrReg   <= '0;
      rdPtrReg   <= '0;
      rrWrReg    <= 1'b1;
      lockedReg  <= 1'b0;
      lockSrcReg <= 1'b0;
    end else begin
      if (accept) wrPtrReg <= wrPtrReg + PtrW'(1);
      if (pop)    rdPtrReg <= rdPtrReg + PtrW'(1);
      if (accept && !pop)      countReg <= countReg + (PtrW + 1)'(1);
      else if (pop && !accept) countReg <= countReg - (PtrW + 1)'(1);
      lockedReg  <= tc_req_valid_o && !tc_req_ready_i;
      lockSrcReg <= grantWr;
      if (accept && rd_req_valid_i && wr_req_valid_i) rrWrReg <= !grantWr;
    end
  end

  // Order entries carry {source is write path, answered locally}.
  always_ff @(posedge clk_i) begin
    if (accept) fifoMem[wrPtrReg] <= {grantWr, !selInRange};
  end

`ifdef AXI_TAGCTRL_ARB_PERF_EN
  logic stall;
  assign stall = (rd_req_valid_i || wr_req_valid_i) && !accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_rd_grants_o <= '0;
      perf_wr_grants_o <= '0;
      perf_stall_o     <= '0;
    end else begin
      if (rd_req_ready_o && perf_rd_grants_o != 32'hFFFF_FFFF) perf_rd_grants_o <= perf_rd_grants_o + 32'd1;
      if (wr_req_ready_o && perf_wr_grants_o != 32'hFFFF_FFFF) perf_wr_grants_o <= perf_wr_grants_o + 32'd1;
      if (stall && perf_stall_o != 32'hFFFF_FFFF) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_tagctrl_tag_arb.sv
// Self-checking bench for axi_tagctrl_tag_arb; responses are checked against a queue of expected results.
module tb_axi_tagctrl_tag_arb;

  localparam int AW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          rd_req_valid_i, rd_req_ready_o;
  logic [AW-1:0] rd_req_addr_i;
  logic          rd_rsp_valid_o, rd_rsp_ready_i, rd_rsp_tag_o, rd_rsp_err_o;
  logic          wr_req_valid_i, wr_req_ready_o;
  logic [AW-1:0] wr_req_addr_i;
  logic          wr_req_tag_i;
  logic          wr_rsp_valid_o, wr_rsp_ready_i, wr_rsp_err_o;
  logic          tc_req_valid_o, tc_req_ready_i;
  logic [AW-1:0] tc_req_addr_o;
  logic          tc_req_we_o;
  logic [5:0]    tc_req_bit_o;
  logic          tc_req_wbit_o;
  logic          tc_rsp_valid_i, tc_rsp_ready_o, tc_rsp_tag_i;
`ifdef AXI_TAGCTRL_ARB_PERF_EN
  logic [31:0]   perf_rd_grants_o, perf_wr_grants_o, perf_stall_o;
`endif

  typedef struct packed {
    logic src;  // 1 = write path
    logic err;
    logic tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;

  axi_tagctrl_tag_arb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o), .rd_req_addr_i(rd_req_addr_i),
    .rd_rsp_valid_o(rd_rsp_valid_o), .rd_rsp_ready_i(rd_rsp_ready_i), .rd_rsp_tag_o(rd_rsp_tag_o),
    .rd_rsp_err_o(rd_rsp_err_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o), .wr_req_addr_i(wr_req_addr_i),
    .wr_req_tag_i(wr_req_tag_i),
    .wr_rsp_valid_o(wr_rsp_valid_o), .wr_rsp_ready_i(wr_rsp_ready_i), .wr_rsp_err_o(wr_rsp_err_o),
    .tc_req_valid_o(tc_req_valid_o), .tc_req_ready_i(tc_req_ready_i), .tc_req_addr_o(tc_req_addr_o),
    .tc_req_we_o(tc_req_we_o), .tc_req_bit_o(tc_req_bit_o), .tc_req_wbit_o(tc_req_wbit_o),
    .tc_rsp_valid_i(tc_rsp_valid_i), .tc_rsp_ready_o(tc_rsp_ready_o), .tc_rsp_tag_i(tc_rsp_tag_i)
`ifdef AXI_TAGCTRL_ARB_PERF_EN
    , .perf_rd_grants_o(perf_rd_grants_o), .perf_wr_grants_o(perf_wr_grants_o), .perf_stall_o(perf_stall_o)
`endif
  );

  task automatic idle_inputs();
    rd_req_valid_i = 0; rd_req_addr_i = '0; rd_rsp_ready_i = 0;
    wr_req_valid_i = 0; wr_req_addr_i = '0; wr_req_tag_i = 0; wr_rsp_ready_i = 0;
    tc_req_ready_i = 0; tc_rsp_valid_i = 0; tc_rsp_tag_i = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk_i); #1;
    idle_inputs();
    rst_ni = 0;
    sb.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    #12;
    checks++;
    if ({rd_req_ready_o, wr_req_ready_o, tc_req_valid_o, tc_rsp_ready_o, rd_rsp_valid_o, wr_rsp_valid_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {rd_req_ready_o, wr_req_ready_o, tc_req_valid_o, tc_rsp_ready_o, rd_rsp_valid_o, wr_rsp_valid_o});
    end
`ifdef AXI_TAGCTRL_ARB_PERF_EN
    checks++;
    if ({perf_rd_grants_o, perf_wr_grants_o, perf_stall_o} !== 96'b0) begin
      errors++; $display("FAIL reset_perf: counters not zero");
    end
`endif
    @(posedge clk_i); #1 rst_ni = 1;
    $display("test_reset done");
  endtask

  task automatic test_read_lookup();
    apply_reset();
    rd_req_valid_i = 1; rd_req_addr_i = 64'h8000_0410; tc_req_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (tc_req_valid_o !== 1 || tc_req_addr_o !== 64'h8FF0_0008 || tc_req_bit_o !== 6'd1 || tc_req_we_o !== 0 || rd_req_ready_o !== 1) begin
      errors++;
      $display("FAIL read_req: got v=%b addr=%h bit=%0d we=%b rdy=%b expected v=1 addr=8ff00008 bit=1 we=0 rdy=1",
               tc_req_valid_o, tc_req_addr_o, tc_req_bit_o, tc_req_we_o, rd_req_ready_o);
    end
    sb.push_back('{src: 1'b0, err: 1'b0, tag: 1'b1});
    @(posedge clk_i); #1;
    rd_req_valid_i = 0; tc_req_ready_i = 0;
    tc_rsp_valid_i = 1; tc_rsp_tag_i = 1; rd_rsp_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (rd_rsp_valid_o !== 1 || tc_rsp_ready_o !== 1 || sb.size() == 0) begin
      errors++; $display("FAIL read_rsp_valid: got v=%b tcrdy=%b expected 1 1", rd_rsp_valid_o, tc_rsp_ready_o);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rd_rsp_tag_o !== e.tag || rd_rsp_err_o !== e.err) begin
        errors++; $display("FAIL read_rsp_data: got tag=%b err=%b expected tag=%b err=%b", rd_rsp_tag_o, rd_rsp_err_o, e.tag, e.err);
      end
    end
    @(posedge clk_i); #1;
    idle_inputs();
    $display("test_read_lookup done");
  endtask

  task automatic test_round_robin();
    int nRsp;
    apply_reset();
    nRsp = 0;
    tc_req_ready_i = 1; rd_rsp_ready_i = 1; wr_rsp_ready_i = 1; tc_rsp_valid_i = 1; tc_rsp_tag_i = 0;
    rd_req_addr_i = 64'h8000_0100; wr_req_addr_i = 64'h8000_0200; wr_req_tag_i = 1;
    for (int i = 0; i < 9; i++) begin
      rd_req_valid_i = (i < 6); wr_req_valid_i = (i < 6);
      @(negedge clk_i);
      if (rd_rsp_valid_o || wr_rsp_valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rr_rsp_unexpected: got response at step %0d expected none", i);
        end else begin
          e = sb.pop_front();
          nRsp++;
          if (wr_rsp_valid_o !== e.src || (rd_rsp_err_o | wr_rsp_err_o) !== e.err) begin
            errors++; $display("FAIL rr_rsp_order: got src=%b expected src=%b", wr_rsp_valid_o, e.src);
          end
        end
      end
      if (i < 6) begin
        checks++;
        if (tc_req_valid_o !== 1 || tc_req_we_o !== (i % 2 == 0)) begin
          errors++; $display("FAIL rr_grant%0d: got v=%b we=%b expected v=1 we=%b", i, tc_req_valid_o, tc_req_we_o, i % 2 == 0);
        end
        sb.push_back('{src: tc_req_we_o, err: 1'b0, tag: 1'b0});
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (nRsp != 6 || sb.size() != 0) begin
      errors++; $display("FAIL rr_rsp_count: got %0d expected 6", nRsp);
    end
`ifdef AXI_TAGCTRL_ARB_PERF_EN
    checks++;
    if (perf_rd_grants_o !== 32'd3 || perf_wr_grants_o !== 32'd3) begin
      errors++; $display("FAIL rr_perf: got rd=%0d wr=%0d expected 3 3", perf_rd_grants_o, perf_wr_grants_o);
    end
`endif
    idle_inputs();
    $display("test_round_robin done");
  endtask

  task automatic test_out_of_range();
    apply_reset();
    wr_req_valid_i = 1; wr_req_addr_i = 64'h7FFF_FFF0; wr_req_tag_i = 1;
    @(negedge clk_i);
    checks++;
    if (tc_req_valid_o !== 0 || wr_req_ready_o !== 1) begin
      errors++; $display("FAIL oor_accept: got tcv=%b rdy=%b expected tcv=0 rdy=1", tc_req_valid_o, wr_req_ready_o);
    end
    sb.push_back('{src: 1'b1, err: 1'b1, tag: 1'b0});
    @(posedge clk_i); #1;
    wr_req_addr_i = 64'h8000_0000; tc_req_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (tc_req_valid_o !== 1 || tc_req_addr_o !== 64'h8FF0_0000 || tc_req_bit_o !== 6'd0 || tc_req_we_o !== 1 || tc_req_wbit_o !== 1) begin
      errors++; $display("FAIL inr_req: got v=%b addr=%h bit=%0d we=%b wbit=%b expected 1 8ff00000 0 1 1",
                         tc_req_valid_o, tc_req_addr_o, tc_req_bit_o, tc_req_we_o, tc_req_wbit_o);
    end
    sb.push_back('{src: 1'b1, err: 1'b0, tag: 1'b0});
    @(posedge clk_i); #1;
    wr_req_valid_i = 0; tc_req_ready_i = 0; tc_rsp_valid_i = 1; wr_rsp_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      e = sb.pop_front();
      checks++;
      if (wr_rsp_valid_o !== 1 || wr_rsp_err_o !== e.err || tc_rsp_ready_o !== !e.err) begin
        errors++; $display("FAIL oor_rsp%0d: got v=%b err=%b tcrdy=%b expected v=1 err=%b tcrdy=%b",
                           i, wr_rsp_valid_o, wr_rsp_err_o, tc_rsp_ready_o, e.err, !e.err);
      end
      @(posedge clk_i); #1;
    end
    idle_inputs();
    $display("test_out_of_range done");
  endtask

  task automatic test_lock();
    apply_reset();
    // One contested grant moves the pointer to the read path.
    rd_req_valid_i = 1; wr_req_valid_i = 1; tc_req_ready_i = 1;
    rd_req_addr_i = 64'h8000_0410; wr_req_addr_i = 64'h8000_0000;
    @(negedge clk_i);
    checks++;
    if (tc_req_we_o !== 1) begin
      errors++; $display("FAIL lock_setup: got we=%b expected 1", tc_req_we_o);
    end
    @(posedge clk_i); #1;
    rd_req_valid_i = 0; tc_req_ready_i = 0; wr_req_addr_i = 64'h8000_1230;
    @(posedge clk_i); #1;
    rd_req_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (tc_req_valid_o !== 1 || tc_req_we_o !== 1 || tc_req_addr_o !== 64'h8FF0_0020 || tc_req_bit_o !== 6'd35 ||
          rd_req_ready_o !== 0 || wr_req_ready_o !== 0) begin
        errors++; $display("FAIL lock_hold%0d: got v=%b we=%b addr=%h bit=%0d rrdy=%b wrdy=%b expected 1 1 8ff00020 35 0 0",
                           i, tc_req_valid_o, tc_req_we_o, tc_req_addr_o, tc_req_bit_o, rd_req_ready_o, wr_req_ready_o);
      end
      @(posedge clk_i); #1;
    end
    tc_req_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (wr_req_ready_o !== 1 || rd_req_ready_o !== 0) begin
      errors++; $display("FAIL lock_release: got wrdy=%b rrdy=%b expected 1 0", wr_req_ready_o, rd_req_ready_o);
    end
    @(posedge clk_i); #1;
    wr_req_valid_i = 0;
    @(negedge clk_i);
    checks++;
    if (rd_req_ready_o !== 1 || tc_req_we_o !== 0) begin
      errors++; $display("FAIL lock_next_read: got rrdy=%b we=%b expected 1 0", rd_req_ready_o, tc_req_we_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    $display("test_lock done");
  endtask

  task automatic test_fifo_full();
    apply_reset();
    rd_req_valid_i = 1; rd_req_addr_i = 64'h8000_0000; tc_req_ready_i = 1; rd_rsp_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (rd_req_ready_o !== (i < 4) || tc_req_valid_o !== (i < 4)) begin
        errors++; $display("FAIL full_issue%0d: got rdy=%b tcv=%b expected %b", i, rd_req_ready_o, tc_req_valid_o, i < 4);
      end
      if (i < 4) sb.push_back('{src: 1'b0, err: 1'b0, tag: 1'b1});
      @(posedge clk_i); #1;
    end
    tc_rsp_valid_i = 1; tc_rsp_tag_i = 1;
    @(negedge clk_i);
    e = sb.pop_front();
    checks++;
    if (rd_rsp_valid_o !== 1 || rd_rsp_tag_o !== e.tag || rd_req_ready_o !== 1) begin
      errors++; $display("FAIL full_pop_push: got rspv=%b tag=%b rdy=%b expected 1 %b 1", rd_rsp_valid_o, rd_rsp_tag_o, e.tag, rd_req_ready_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    $display("test_fifo_full done");
  endtask

  task automatic test_reset_midway();
    apply_reset();
    rd_req_valid_i = 1; rd_req_addr_i = 64'h8000_0040; tc_req_ready_i = 1;
    repeat (2) @(posedge clk_i);
    #1 idle_inputs();
    tc_rsp_valid_i = 1; rd_rsp_ready_i = 1;
    rst_ni = 0;
    @(negedge clk_i);
    checks++;
    if ({rd_req_ready_o, wr_req_ready_o, tc_req_valid_o, tc_rsp_ready_o, rd_rsp_valid_o, wr_rsp_valid_o} !== 6'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 000000",
                         {rd_req_ready_o, wr_req_ready_o, tc_req_valid_o, tc_rsp_ready_o, rd_rsp_valid_o, wr_rsp_valid_o});
    end
`ifdef AXI_TAGCTRL_ARB_PERF_EN
    checks++;
    if ({perf_rd_grants_o, perf_wr_grants_o, perf_stall_o} !== 96'b0) begin
      errors++; $display("FAIL midreset_perf: counters not zero");
    end
`endif
    @(posedge clk_i); #1 rst_ni = 1;
    sb.delete();
    @(negedge clk_i);
    checks++;
    if (tc_rsp_ready_o !== 0 || rd_rsp_valid_o !== 0) begin
      errors++; $display("FAIL stray_rsp: got tcrdy=%b rspv=%b expected 0 0", tc_rsp_ready_o, rd_rsp_valid_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    $display("test_reset_midway done");
  endtask

  initial begin
    test_reset();
    test_read_lookup();
    test_round_robin();
    test_out_of_range();
    test_lock();
    test_fifo_full();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
